dmu_sii_rx: RTL and testbench

Inbound receive stage on the SII side of the DMU→SII interface, clocked by `iol2clk`. It decodes each DMU header cycle, collects the payload beats that follow, checks beat parity and queues complete packets in a small FIFO for the SII inbound queues. For every DMA write the consumer accepts, it returns one `sii_dmu_wrack_vld` pulse with its tag.

---
 rtl/dmu_sii_pkg.sv | 29 ++
 rtl/dmu_sii_pkt_fifo.sv | 54 +++++
 rtl/dmu_sii_rx.sv | 159 +++++++++++++++
 tb/tb_dmu_sii_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmu_sii_pkg.sv
// Shared types and constants for the DMU->SII inbound receive path.
package dmu_sii_pkg;

    localparam int WR_BEATS      = 4;
    localparam int WRACK_TAG_LSB = 64;
    localparam int WRACK_TAG_MSB = 67;

    typedef enum logic [1:0] {
        READ     = 2'd0,
        WRITE    = 2'd1,
        INTR_PIO = 2'd2
    } pkt_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PL  = 2'd1,
        INT_PL = 2'd2
    } rx_state_e;

    typedef struct packed {
        pkt_type_e      ptype;
        logic           bypass;
        logic [127:0]   hdr;
        logic [511:0]   data;
        logic [15:0]    be;
        logic           perr;
    } pkt_s;

endpackage

// File: rtl/dmu_sii_pkt_fifo.sv
// Shift-register packet FIFO; the head always sits in entry 0 so it is
// driven straight from flops. Push and pop may share a cycle when full.
module dmu_sii_pkt_fifo
    import dmu_sii_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  pkt_s push_pkt,
    input  logic pop,
    output logic full,
    output logic empty,
    output pkt_s head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pkt_s           mem [DEPTH];
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_n;
    logic           nonempty;
    logic           pop_ok;
    logic           push_ok;
    logic [AW-1:0]  wr_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = !nonempty;
    assign head    = mem[0];
    assign pop_ok  = pop & nonempty;
    assign push_ok = push & (!full | pop_ok);
    assign wr_idx  = pop_ok ? AW'(count - CW'(1)) : AW'(count);
    assign count_n = count + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            nonempty <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            count    <= count_n;
            nonempty <= (count_n != '0);
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
                mem[DEPTH-1] <= '0;
            end
            // Later assignment wins over the shift for the slot being filled
            if (push_ok) mem[wr_idx] <= push_pkt;
        end
    end

endmodule

// File: rtl/dmu_sii_rx.sv
// DMU->SII inbound receive stage: header decode, payload capture, packet queue.
// Optional beat parity checking is built when DMU_SII_RX_PARITY_CHK_EN is defined.
module dmu_sii_rx
    import dmu_sii_pkg::*;
#(
    parameter int PKT_DEPTH = 4
) (
    input  logic           iol2clk,
    input  logic           rst,
    input  logic           dmu_sii_hdr_vld,
    input  logic           dmu_sii_datareq,
    input  logic           dmu_sii_datareq16,
    input  logic           dmu_sii_reqbypass,
    input  logic [127:0]   dmu_sii_data,
    input  logic [7:0]     dmu_sii_parity,
    input  logic [15:0]    dmu_sii_be,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [1:0]     out_type,
    output logic           out_bypass,
    output logic [127:0]   out_hdr,
    output logic [511:0]   out_data,
    output logic [15:0]    out_be,
    output logic           out_perr,
    output logic           sii_dmu_wrack_vld,
    output logic [3:0]     sii_dmu_wrack_tag,
    output logic           err_proto,
    output logic           err_ovf,
    output logic           err_parity
);

    rx_state_e  state, state_n;
    logic [1:0] beat, beat_n;
    pkt_s       cur, cur_n, hdr_pkt, push_pkt, head;
    logic       push, pop, full, empty, proto_set, par_bad;

    dmu_sii_pkt_fifo #(.DEPTH(PKT_DEPTH)) u_fifo (
        .clk      (iol2clk),
        .rst      (rst),
        .push     (push),
        .push_pkt (push_pkt),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

`ifdef DMU_SII_RX_PARITY_CHK_EN
    logic [7:0] par_calc;
    always_comb begin
        par_calc = '0;
        for (int i = 0; i < 8; i++) par_calc[i] = ^dmu_sii_data[16*i +: 16];
    end
    assign par_bad  = |(par_calc ^ dmu_sii_parity);
    assign out_perr = head.perr;

    always_ff @(posedge iol2clk) begin
        if (rst)
            err_parity <= 1'b0;
        else if (par_bad && (dmu_sii_hdr_vld || state != IDLE))
            err_parity <= 1'b1;
    end
`else
    logic unused_par;
    assign unused_par = head.perr ^ (^dmu_sii_parity);
    assign par_bad    = 1'b0;
    assign out_perr   = 1'b0;
    assign err_parity = 1'b0;
`endif

    assign out_vld    = !empty;
    assign out_type   = head.ptype;
    assign out_bypass = head.bypass;
    assign out_hdr    = head.hdr;
    assign out_data   = head.data;
    assign out_be     = head.be;
    assign pop        = out_vld & out_rdy;

    always_comb begin
        hdr_pkt        = '0;
        hdr_pkt.ptype  = READ;
        hdr_pkt.bypass = dmu_sii_reqbypass;
        hdr_pkt.hdr    = dmu_sii_data;
        hdr_pkt.be     = dmu_sii_be;
        hdr_pkt.perr   = par_bad;
        state_n        = state;
        beat_n         = beat;
        cur_n          = cur;
        push           = 1'b0;
        push_pkt       = cur;
        proto_set      = 1'b0;
        if (dmu_sii_hdr_vld) begin
            // A header always restarts decode; mid-packet it abandons the old one
            proto_set = (state != IDLE);
            state_n   = IDLE;
            case ({dmu_sii_datareq, dmu_sii_datareq16})
                2'b00: begin
                    push     = 1'b1;
                    push_pkt = hdr_pkt;
                end
                2'b10: begin
                    cur_n       = hdr_pkt;
                    cur_n.ptype = WRITE;
                    beat_n      = '0;
                    state_n     = WR_PL;
                end
                2'b11: begin
                    cur_n       = hdr_pkt;
                    cur_n.ptype = INTR_PIO;
                    state_n     = INT_PL;
                end
                default: proto_set = 1'b1;
            endcase
        end else begin
            case (state)
                WR_PL: begin
                    cur_n.data[{beat, 7'd0} +: 128] = dmu_sii_data;
                    cur_n.perr = cur.perr | par_bad;
                    beat_n     = beat + 2'd1;
                    if (beat == 2'(WR_BEATS - 1)) begin
                        push     = 1'b1;
                        push_pkt = cur_n;
                        state_n  = IDLE;
                    end
                end
                INT_PL: begin
                    cur_n.data = {384'd0, dmu_sii_data};
                    cur_n.perr = cur.perr | par_bad;
                    push       = 1'b1;
                    push_pkt   = cur_n;
                    state_n    = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state             <= IDLE;
            beat              <= '0;
            cur               <= '0;
            sii_dmu_wrack_vld <= 1'b0;
            sii_dmu_wrack_tag <= '0;
            err_proto         <= 1'b0;
            err_ovf           <= 1'b0;
        end else begin
            state             <= state_n;
            beat              <= beat_n;
            cur               <= cur_n;
            sii_dmu_wrack_vld <= pop && (head.ptype == WRITE);
            if (pop && head.ptype == WRITE)
                sii_dmu_wrack_tag <= head.hdr[WRACK_TAG_MSB:WRACK_TAG_LSB];
            if (proto_set) err_proto <= 1'b1;
            if (push && full && !pop) err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmu_sii_rx.sv
// Directed self-checking bench for dmu_sii_rx.
module tb_dmu_sii_rx;

`ifdef DMU_SII_RX_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           hdr_vld, datareq, datareq16, reqbypass;
    logic [127:0]   data;
    logic [7:0]     parity;
    logic [15:0]    be;
    logic           out_vld, out_rdy, out_bypass, out_perr;
    logic [1:0]     out_type;
    logic [127:0]   out_hdr;
    logic [511:0]   out_data;
    logic [15:0]    out_be;
    logic           wrack_vld;
    logic [3:0]     wrack_tag;
    logic           err_proto, err_ovf, err_parity;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmu_sii_rx #(.PKT_DEPTH(4)) dut (
        .iol2clk           (clk),
        .rst               (rst),
        .dmu_sii_hdr_vld   (hdr_vld),
        .dmu_sii_datareq   (datareq),
        .dmu_sii_datareq16 (datareq16),
        .dmu_sii_reqbypass (reqbypass),
        .dmu_sii_data      (data),
        .dmu_sii_parity    (parity),
        .dmu_sii_be        (be),
        .out_vld           (out_vld),
        .out_rdy           (out_rdy),
        .out_type          (out_type),
        .out_bypass        (out_bypass),
        .out_hdr           (out_hdr),
        .out_data          (out_data),
        .out_be            (out_be),
        .out_perr          (out_perr),
        .sii_dmu_wrack_vld (wrack_vld),
        .sii_dmu_wrack_tag (wrack_tag),
        .err_proto         (err_proto),
        .err_ovf           (err_ovf),
        .err_parity        (err_parity)
    );

    function automatic logic [7:0] par_of(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hdr(input logic dr, input logic d16, input logic byp,
                             input logic [127:0] d, input logic [15:0] b);
        hdr_vld   = 1'b1;
        datareq   = dr;
        datareq16 = d16;
        reqbypass = byp;
        data      = d;
        parity    = par_of(d);
        be        = b;
    endtask

    task automatic drive_beat(input logic [127:0] d, input logic [7:0] flip);
        hdr_vld = 1'b0;
        data    = d;
        parity  = par_of(d) ^ flip;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        hdr_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        datareq = 0; datareq16 = 0; reqbypass = 0;
        data = '0; parity = '0; be = '0; out_rdy = 0;
        do_reset();
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL rst_vld got %b want 0", out_vld); end
        tests++; if (out_hdr !== '0 || out_data !== '0 || out_be !== '0) begin fails++; $display("FAIL rst_data hdr %h be %h", out_hdr, out_be); end
        tests++; if (wrack_vld !== 1'b0 || wrack_tag !== 4'h0) begin fails++; $display("FAIL rst_wrack got %b/%h want 0/0", wrack_vld, wrack_tag); end
        tests++; if ({err_proto, err_ovf, err_parity} !== 3'b000) begin fails++; $display("FAIL rst_err got %b want 000", {err_proto, err_ovf, err_parity}); end
    endtask

    task automatic test_read();
        out_rdy = 1;
        drive_hdr(0, 0, 1, 128'h1234, 16'hFFFF);
        tick();
        hdr_vld = 0;
        tests++; if (out_vld !== 1'b1) begin fails++; $display("FAIL read_vld got %b want 1", out_vld); end
        tests++; if (out_type !== 2'd0 || out_bypass !== 1'b1) begin fails++; $display("FAIL read_type got %0d/%b want 0/1", out_type, out_bypass); end
        tests++; if (out_hdr !== 128'h1234 || out_perr !== 1'b0) begin fails++; $display("FAIL read_hdr got %h/%b want 1234/0", out_hdr, out_perr); end
        tick();
        tests++; if (out_vld !== 1'b0 || wrack_vld !== 1'b0) begin fails++; $display("FAIL read_pop got vld %b wrack %b want 0/0", out_vld, wrack_vld); end
    endtask

    task automatic test_write();
        logic [127:0] b0, b1, b2, b3;
        b0 = {16{8'h11}}; b1 = {16{8'h22}}; b2 = {16{8'h33}}; b3 = {16{8'h44}};
        out_rdy = 0;
        drive_hdr(1, 0, 0, 128'h0000_0000_0000_000A_0000_0000_0000_0055, 16'h00FF);
        tick();
        drive_beat(b0, 8'h00); tick();
        drive_beat(b1, 8'h00); tick();
        drive_beat(b2, 8'h00); tick();
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL wr_early got %b want 0", out_vld); end
        drive_beat(b3, 8'h00); tick();
        data = '0;
        tests++; if (out_vld !== 1'b1 || out_type !== 2'd1) begin fails++; $display("FAIL wr_vld got %b/%0d want 1/1", out_vld, out_type); end
        tests++; if (out_data !== {b3, b2, b1, b0}) begin fails++; $display("FAIL wr_data got %h", out_data); end
        tests++; if (out_be !== 16'h00FF) begin fails++; $display("FAIL wr_be got %h want 00ff", out_be); end
        tick();
        tests++; if (out_vld !== 1'b1 || out_data !== {b3, b2, b1, b0} || wrack_vld !== 1'b0) begin fails++; $display("FAIL wr_hold got vld %b wrack %b", out_vld, wrack_vld); end
        out_rdy = 1;
        tick();
        tests++; if (wrack_vld !== 1'b1 || wrack_tag !== 4'hA) begin fails++; $display("FAIL wr_ack got %b/%h want 1/a", wrack_vld, wrack_tag); end
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL wr_popped got %b want 0", out_vld); end
        tick();
        tests++; if (wrack_vld !== 1'b0) begin fails++; $display("FAIL wr_ack_pulse got %b want 0", wrack_vld); end
    endtask

    task automatic test_intr_parity();
        logic [127:0] pl;
        pl = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        out_rdy = 0;
        drive_hdr(1, 1, 0, 128'h77, 16'h0001);
        tick();
        drive_beat(pl, 8'h08);
        tick();
        parity = par_of(data);
        tests++; if (out_vld !== 1'b1 || out_type !== 2'd2 || out_bypass !== 1'b0) begin fails++; $display("FAIL int_type got %b/%0d/%b want 1/2/0", out_vld, out_type, out_bypass); end
        tests++; if (out_data !== {384'd0, pl}) begin fails++; $display("FAIL int_data got %h", out_data); end
        tests++; if (out_perr !== PAR_EN || err_parity !== PAR_EN) begin fails++; $display("FAIL int_perr got %b/%b want %b", out_perr, err_parity, PAR_EN); end
        out_rdy = 1;
        tick();
        tests++; if (out_vld !== 1'b0 || wrack_vld !== 1'b0) begin fails++; $display("FAIL int_noack got %b/%b want 0/0", out_vld, wrack_vld); end
    endtask

    task automatic test_proto_abort();
        do_reset();
        out_rdy = 0;
        drive_hdr(1, 0, 0, 128'h0000_0000_0000_0005_0000_0000_0000_0000, 16'hFFFF);
        tick();
        drive_beat({16{8'h11}}, 8'h00); tick();
        tests++; if (err_proto !== 1'b0) begin fails++; $display("FAIL abort_pre got %b want 0", err_proto); end
        drive_hdr(0, 0, 0, 128'hBEEF, 16'h0003);
        tick();
        tests++; if (err_proto !== 1'b1) begin fails++; $display("FAIL abort_err got %b want 1", err_proto); end
        tests++; if (out_vld !== 1'b1 || out_type !== 2'd0 || out_hdr !== 128'hBEEF) begin fails++; $display("FAIL abort_new got %b/%0d/%h", out_vld, out_type, out_hdr); end
        for (int i = 0; i < 3; i++) begin drive_beat({16{8'h33}}, 8'h00); tick(); end
        out_rdy = 1;
        tick();
        tests++; if (out_vld !== 1'b0 || wrack_vld !== 1'b0) begin fails++; $display("FAIL abort_only got %b/%b want 0/0", out_vld, wrack_vld); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_rdy = 0;
        for (int i = 0; i < 4; i++) begin drive_hdr(0, 0, 0, 128'(i), 16'h0); tick(); end
        tests++; if (err_ovf !== 1'b0 || out_vld !== 1'b1) begin fails++; $display("FAIL ovf_full got %b/%b want 0/1", err_ovf, out_vld); end
        drive_hdr(0, 0, 0, 128'h99, 16'h0);
        tick();
        hdr_vld = 0;
        tests++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", err_ovf); end
        out_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_vld !== 1'b1 || out_hdr !== 128'(i)) begin fails++; $display("FAIL ovf_drain%0d got %b/%h want 1/%0d", i, out_vld, out_hdr, i); end
            tick();
        end
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL ovf_dropped got %b want 0", out_vld); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_rdy = 0;
        for (int i = 0; i < 4; i++) begin drive_hdr(0, 0, 0, 128'(10 + i), 16'h0); tick(); end
        out_rdy = 1;
        drive_hdr(0, 0, 0, 128'd14, 16'h0);
        tick();
        hdr_vld = 0;
        tests++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL b2b_ovf got %b want 0", err_ovf); end
        for (int i = 11; i < 15; i++) begin
            tests++; if (out_vld !== 1'b1 || out_hdr !== 128'(i)) begin fails++; $display("FAIL b2b_drain got %b/%h want 1/%0d", out_vld, out_hdr, i); end
            tick();
        end
        drive_hdr(1, 1, 1, 128'h5, 16'h0); tick();
        drive_beat(128'hAB, 8'h00); tick();
        drive_hdr(0, 0, 1, 128'h6, 16'h0); tick();
        hdr_vld = 0;
        tests++; if (err_proto !== 1'b0) begin fails++; $display("FAIL b2b_proto got %b want 0", err_proto); end
    endtask

    task automatic test_illegal_and_reset();
        do_reset();
        out_rdy = 0;
        drive_hdr(0, 1, 0, 128'h42, 16'h0);
        tick();
        hdr_vld = 0;
        tests++; if (err_proto !== 1'b1 || out_vld !== 1'b0) begin fails++; $display("FAIL illegal got %b/%b want 1/0", err_proto, out_vld); end
        drive_hdr(0, 0, 0, 128'h7, 16'h0); tick();
        drive_hdr(1, 0, 0, 128'h8, 16'hFFFF); tick();
        drive_beat({16{8'h11}}, 8'h00); tick();
        rst = 1;
        drive_beat({16{8'h22}}, 8'h00); tick();
        rst = 0;
        tests++; if (out_vld !== 1'b0 || out_hdr !== '0 || out_data !== '0) begin fails++; $display("FAIL midrst_out got %b/%h", out_vld, out_hdr); end
        tests++; if ({err_proto, err_ovf, err_parity, wrack_vld} !== 4'b0000) begin fails++; $display("FAIL midrst_err got %b want 0000", {err_proto, err_ovf, err_parity, wrack_vld}); end
        for (int i = 0; i < 3; i++) begin drive_beat({16{8'h33}}, 8'h00); tick(); end
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL midrst_stale got %b want 0", out_vld); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_intr_parity();
        test_proto_abort();
        test_overflow();
        test_back_to_back();
        test_illegal_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
